// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Raster timing bundle between the VGA timing generator and its consumers.
//   pix_ce      : pixel clock-enable, driven by the consumer side
//   HS, VS      : horizontal / vertical sync
//   blank, de   : outside-active flag and its complement
//   hcounter    : current pixel column (CNT_W bits)
//   vcounter    : current line (CNT_W bits)
//   line_start  : one-cycle strobe at column 0 of each line
//   frame_start : one-cycle strobe at pixel (0,0)
//   frame_cnt   : 8-bit frame counter
// Modports: master = timing generator, slave = renderer / pixel consumer.
// -----------------------------------------------------------------------------
interface vga_timing_gen_if #(
    parameter int CNT_W = 11
);
    logic             pix_ce;
    logic             HS;
    logic             VS;
    logic             blank;
    logic             de;
    logic [CNT_W-1:0] hcounter;
    logic [CNT_W-1:0] vcounter;
    logic             line_start;
    logic             frame_start;
    logic [7:0]       frame_cnt;

    modport master (
        input  pix_ce,
        output HS, VS, blank, de, hcounter, vcounter,
        output line_start, frame_start, frame_cnt
    );

    modport slave (
        output pix_ce,
        input  HS, VS, blank, de, hcounter, vcounter,
        input  line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised progressive-scan raster timing generator. Free-running h/v
// counters advance on pix_ce; all outputs are registered from the current
// (h,v) on the same edge so coordinates, syncs and blanking describe the
// same pixel.
//   pixel_clk : the only clock
//   rst       : synchronous, active-high reset (priority over pix_ce)
//   bus       : vga_timing_gen_if.master (pix_ce in, all timing outputs out)
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN
//   defined   -> 8-bit frame counter, incremented with every frame_start
//   undefined -> frame_cnt tied to 0
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 11
) (
    input  logic                pixel_clk,
    input  logic                rst,
    vga_timing_gen_if.master    bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             ce;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;

    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] vcnt_q;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             blank_q, blank_d;
    logic             ls_q, ls_d;
    logic             fs_q, fs_d;

    assign ce = bus.pix_ce;

    // Next raster position and decode of the current one.
    always_comb begin
        h_d     = h_q + ONE;
        v_d     = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + ONE;
        end
        hs_d    = (h_q >= HS_BEGIN && h_q < HS_END) ? HS_POL : ~HS_POL;
        // VS is decoded per pixel, so its edges land on h = 0.
        vs_d    = (v_q >= VS_BEGIN && v_q < VS_END) ? VS_POL : ~VS_POL;
        blank_d = !(h_q < H_ACT_C && v_q < V_ACT_C);
        ls_d    = (h_q == '0);
        fs_d    = (h_q == '0) && (v_q == '0);
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            h_q     <= '0;
            v_q     <= '0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            blank_q <= 1'b1;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else if (ce) begin
            h_q     <= h_d;
            v_q     <= v_d;
            hcnt_q  <= h_q;
            vcnt_q  <= v_q;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end else begin
            // Strobes are single pixel_clk pulses; everything else holds.
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] fcnt_q;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            fcnt_q <= '0;
        end else if (ce && fs_d) begin
            fcnt_q <= fcnt_q + 8'd1;
        end
    end

    assign bus.frame_cnt = fcnt_q;
`else
    assign bus.frame_cnt = 8'd0;
`endif

    assign bus.hcounter    = hcnt_q;
    assign bus.vcounter    = vcnt_q;
    assign bus.HS          = hs_q;
    assign bus.VS          = vs_q;
    assign bus.blank       = blank_q;
    assign bus.de          = ~blank_q;
    assign bus.line_start  = ls_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
    // Reduced raster so whole frames (and 256 of them) stay short.
    localparam int HA  = 8;
    localparam int HF  = 2;
    localparam int HSW = 3;
    localparam int HB  = 2;
    localparam int VA  = 5;
    localparam int VF  = 1;
    localparam int VSW = 2;
    localparam int VB  = 1;
    localparam int HT  = HA + HF + HSW + HB;   // 15
    localparam int VT  = VA + VF + VSW + VB;   // 9
    localparam int FRAME = HT * VT;            // 135
    localparam int CW  = 5;
    localparam int VW  = 6 + 8 + 2 * CW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_ce = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model state: pix_ce edges since reset, and whether the last edge had pix_ce.
    int n = 0;
    bit ce_last = 1'b0;

    vga_timing_gen_if #(.CNT_W(CW)) bus1 ();
    vga_timing_gen_if #(.CNT_W(CW)) bus2 ();

    assign bus1.pix_ce = pix_ce;
    assign bus2.pix_ce = pix_ce;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CW)
    ) dut1 (
        .pixel_clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(CW)
    ) dut2 (
        .pixel_clk(clk),
        .rst(rst),
        .bus(bus2)
    );

    always #5 clk = ~clk;

    logic [VW-1:0] got1, got2;
    assign got1 = {bus1.HS, bus1.VS, bus1.blank, bus1.de, bus1.line_start,
                   bus1.frame_start, bus1.frame_cnt, bus1.hcounter, bus1.vcounter};
    assign got2 = {bus2.HS, bus2.VS, bus2.blank, bus2.de, bus2.line_start,
                   bus2.frame_start, bus2.frame_cnt, bus2.hcounter, bus2.vcounter};

    // Expected output set after n pix_ce edges: the pixel with linear index n-1.
    function automatic logic [VW-1:0] exp_vec(input int cnt, input bit cel,
                                              input bit hp, input bit vp);
        int p, h, v;
        logic hs, vs, bl, ls, fs;
        logic [7:0] fc;
        if (cnt == 0) begin
            h = 0; v = 0; bl = 1'b1; hs = ~hp; vs = ~vp;
            ls = 1'b0; fs = 1'b0; fc = 8'd0;
        end else begin
            p  = cnt - 1;
            h  = p % HT;
            v  = (p / HT) % VT;
            bl = !(h < HA && v < VA);
            hs = (h >= HA + HF && h < HA + HF + HSW) ? hp : ~hp;
            vs = (v >= VA + VF && v < VA + VF + VSW) ? vp : ~vp;
            ls = cel && (h == 0);
            fs = ls && (v == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
            fc = 8'(((p / FRAME) + 1) % 256);
`else
            fc = 8'd0;
`endif
        end
        return {hs, vs, bl, ~bl, ls, fs, fc, CW'(h), CW'(v)};
    endfunction

    // Drive one clock edge and advance the reference model.
    task automatic step(input bit r, input bit ce);
        rst = r;
        pix_ce = ce;
        @(posedge clk);
        #1;
        if (r) begin
            n = 0;
            ce_last = 1'b0;
        end else begin
            if (ce) n++;
            ce_last = ce;
        end
    endtask

    task automatic test_reset;
        logic [VW-1:0] e;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            e = exp_vec(n, ce_last, 1'b0, 1'b0);
            checks++;
            if (got1 !== e) begin
                errors++;
                $display("FAIL reset_hold got %h exp %h", got1, e);
            end
        end
        checks++;
        if ({bus1.HS, bus1.VS, bus1.blank, bus1.de} !== 4'b1110) begin
            errors++;
            $display("FAIL reset_levels got %b exp 1110", {bus1.HS, bus1.VS, bus1.blank, bus1.de});
        end
        step(1'b0, 1'b1);
        e = exp_vec(n, ce_last, 1'b0, 1'b0);
        checks++;
        if (got1 !== e) begin
            errors++;
            $display("FAIL reset_first_pixel got %h exp %h", got1, e);
        end
        checks++;
        if ({bus1.line_start, bus1.frame_start, bus1.blank} !== 3'b110) begin
            errors++;
            $display("FAIL reset_first_strobes got %b exp 110",
                     {bus1.line_start, bus1.frame_start, bus1.blank});
        end
    endtask

    task automatic test_horizontal;
        logic [VW-1:0] e;
        int hs_low = 0;
        int maxh = 0;
        int last_ls = -1;
        step(1'b1, 1'b0);
        for (int i = 0; i < 3 * HT; i++) begin
            step(1'b0, 1'b1);
            e = exp_vec(n, ce_last, 1'b0, 1'b0);
            checks++;
            if (got1 !== e) begin
                errors++;
                $display("FAIL horiz_pixel got %h exp %h", got1, e);
            end
            if (bus1.HS == 1'b0) hs_low++;
            if (int'(bus1.hcounter) > maxh) maxh = int'(bus1.hcounter);
            if (bus1.line_start) begin
                if (last_ls >= 0) begin
                    checks++;
                    if (i - last_ls != HT) begin
                        errors++;
                        $display("FAIL line_period got %0d exp %0d", i - last_ls, HT);
                    end
                end
                last_ls = i;
            end
        end
        checks++;
        if (hs_low != 3 * HSW) begin
            errors++;
            $display("FAIL hsync_width got %0d exp %0d", hs_low, 3 * HSW);
        end
        checks++;
        if (maxh != HT - 1) begin
            errors++;
            $display("FAIL hcounter_max got %0d exp %0d", maxh, HT - 1);
        end
    endtask

    task automatic test_vertical;
        logic [VW-1:0] e;
        int vs_low = 0;
        int last_fs = -1;
        int wraps = 0;
        int prev_v = 0;
        step(1'b1, 1'b0);
        for (int i = 0; i < 2 * FRAME + 1; i++) begin
            step(1'b0, 1'b1);
            e = exp_vec(n, ce_last, 1'b0, 1'b0);
            checks++;
            if (got1 !== e) begin
                errors++;
                $display("FAIL vert_pixel got %h exp %h", got1, e);
            end
            if (i < 2 * FRAME && bus1.VS == 1'b0) vs_low++;
            if (bus1.frame_start) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (i - last_fs != FRAME) begin
                        errors++;
                        $display("FAIL frame_period got %0d exp %0d", i - last_fs, FRAME);
                    end
                end
                last_fs = i;
            end
            if (prev_v == VT - 1 && int'(bus1.vcounter) != prev_v) begin
                wraps++;
                checks++;
                if (bus1.vcounter !== '0) begin
                    errors++;
                    $display("FAIL vcounter_wrap got %0d exp 0", bus1.vcounter);
                end
            end
            prev_v = int'(bus1.vcounter);
        end
        checks++;
        if (vs_low != 2 * VSW * HT) begin
            errors++;
            $display("FAIL vsync_width got %0d exp %0d", vs_low, 2 * VSW * HT);
        end
        checks++;
        if (wraps != 2) begin
            errors++;
            $display("FAIL vcounter_wrap_count got %0d exp 2", wraps);
        end
    endtask

    task automatic test_clock_enable;
        logic [VW-1:0] e;
        int last_fs = -1;
        bit prev_fs = 1'b0;
        bit ce;
        step(1'b1, 1'b0);
        for (int i = 0; i < 4 * FRAME + 4; i++) begin
            step(1'b0, (i % 2) == 0);
            e = exp_vec(n, ce_last, 1'b0, 1'b0);
            checks++;
            if (got1 !== e) begin
                errors++;
                $display("FAIL ce_alt_pixel got %h exp %h", got1, e);
            end
            if (bus1.frame_start) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (i - last_fs != 2 * FRAME) begin
                        errors++;
                        $display("FAIL ce_frame_period got %0d exp %0d", i - last_fs, 2 * FRAME);
                    end
                end
                last_fs = i;
                checks++;
                if (prev_fs) begin
                    errors++;
                    $display("FAIL ce_strobe_len got 2 exp 1");
                end
            end
            prev_fs = bus1.frame_start;
        end
        // Random enable pattern.
        for (int i = 0; i < 3 * FRAME; i++) begin
            ce = 1'($urandom_range(0, 1));
            step(1'b0, ce);
            e = exp_vec(n, ce_last, 1'b0, 1'b0);
            checks++;
            if (got1 !== e) begin
                errors++;
                $display("FAIL ce_rand_pixel got %h exp %h", got1, e);
            end
        end
    endtask

    task automatic test_mid_frame_reset;
        logic [VW-1:0] e;
        bit found = 1'b0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)));
            if (bus1.hcounter == CW'(5) && bus1.vcounter == CW'(3)) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_reach got 0 exp 1");
        end
        step(1'b1, 1'b1);
        e = exp_vec(n, ce_last, 1'b0, 1'b0);
        checks++;
        if (got1 !== e) begin
            errors++;
            $display("FAIL midreset_values got %h exp %h", got1, e);
        end
        step(1'b0, 1'b1);
        e = exp_vec(n, ce_last, 1'b0, 1'b0);
        checks++;
        if (got1 !== e || bus1.frame_start !== 1'b1) begin
            errors++;
            $display("FAIL midreset_first_pixel got %h exp %h", got1, e);
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1);
            e = exp_vec(n, ce_last, 1'b0, 1'b0);
            checks++;
            if (got1 !== e) begin
                errors++;
                $display("FAIL midreset_run got %h exp %h", got1, e);
            end
        end
    endtask

    task automatic test_polarity;
        logic [VW-1:0] e;
        step(1'b1, 1'b1);
        checks++;
        if ({bus2.HS, bus2.VS} !== 2'b00) begin
            errors++;
            $display("FAIL pol_reset got %b exp 00", {bus2.HS, bus2.VS});
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 1'($urandom_range(0, 3) != 0));
            e = exp_vec(n, ce_last, 1'b1, 1'b1);
            checks++;
            if (got2 !== e) begin
                errors++;
                $display("FAIL pol_pixel got %h exp %h", got2, e);
            end
        end
    endtask

    task automatic test_frame_cnt;
        logic [VW-1:0] e;
        logic [7:0] before_wrap;
        step(1'b1, 1'b0);
        for (int i = 0; i < 256 * FRAME + 2; i++) begin
            step(1'b0, 1'b1);
            e = exp_vec(n, ce_last, 1'b0, 1'b0);
            checks++;
            if (got1 !== e) begin
                errors++;
                $display("FAIL fcnt_pixel got %h exp %h", got1, e);
            end
            if (i == 255 * FRAME - 1) before_wrap = bus1.frame_cnt;
            if (i == 255 * FRAME) begin
`ifdef VGA_TIMING_FRAME_CNT_EN
                checks++;
                if (before_wrap !== 8'd255 || bus1.frame_cnt !== 8'd0) begin
                    errors++;
                    $display("FAIL fcnt_wrap got %0d->%0d exp 255->0", before_wrap, bus1.frame_cnt);
                end
`else
                checks++;
                if (before_wrap !== 8'd0 || bus1.frame_cnt !== 8'd0) begin
                    errors++;
                    $display("FAIL fcnt_const got %0d->%0d exp 0->0", before_wrap, bus1.frame_cnt);
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_vertical();
        test_clock_enable();
        test_mid_frame_reset();
        test_polarity();
        test_frame_cnt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It produces horizontal/vertical sync, blanking, data-enable, pixel coordinates and line/frame strobes for any progressive video mode. The block sits between the pixel clock domain and the pixel renderers (ball/maze drawing logic), which consume `hcounter`/`vcounter` and `blank`. Compared with the previous controller it adds:
- separate porch/sync-width parameters and sync polarity per axis
- a pixel clock-enable
- synchronous reset
- line/frame start strobes
- registered, mutually aligned outputs

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: horizontal sync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `HS_POL`, 0: active level of `HS`
- `VS_POL`, 0: active level of `VS`
- `CNT_W`, 11: counter width; must satisfy 2^CNT_W > max(H_TOTAL, V_TOTAL)

Ports:
- `pixel_clk`, input, 1: the only clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `pix_ce`, input, 1: pixel enable; all state advances only on edges where it is 1.
- `HS`, output, 1: horizontal sync.
- `VS`, output, 1: vertical sync.
- `blank`, output, 1: high outside the active area.
- `de`, output, 1: data enable; always equals `~blank`.
- `hcounter`, output, CNT_W: current pixel column.
- `vcounter`, output, CNT_W: current line.
- `line_start`, output, 1: one-cycle strobe at column 0 of every line.
- `frame_start`, output, 1: one-cycle strobe at pixel (0,0).
- `frame_cnt`, output, 8: frame counter (see Configuration).

## Operation
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800), V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Internal counters h and v both start at 0.
- On each `pix_ce` edge:
  - h increments.
  - At h = H_TOTAL-1, h wraps to 0 and v increments.
  - At v = V_TOTAL-1 with h = H_TOTAL-1, v wraps to 0.
  - There is no overrun: the last column is H_TOTAL-1, not H_TOTAL.
- On the same `pix_ce` edge, the output registers load values decoded from the current (h,v):
  - `hcounter` = h, `vcounter` = v
  - `blank` = !(h < H_ACTIVE && v < V_ACTIVE)
  - `HS` = HS_POL when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL
  - `VS` = VS_POL when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL
  - The VS window is evaluated per pixel, so VS edges coincide with h = 0.
- Consistency: every output set describes the same single pixel. There is no skew between coordinates and syncs.
- Strobes:
  - `line_start` is 1 for exactly one `pixel_clk` cycle, immediately after the `pix_ce` edge that loads h = 0.
  - `frame_start` is 1 for one cycle after the edge that loads (0,0).
  - Both strobes are 0 on all other cycles, including cycles where `pix_ce` = 0.
- While `pix_ce` = 0, all non-strobe outputs hold their values.
- Reset (`rst` = 1 at an edge) takes priority over `pix_ce`. It applies identically mid-line or mid-frame.
  - Reset values: h = v = 0, `hcounter` = `vcounter` = 0, `HS` = ~HS_POL, `VS` = ~VS_POL, `blank` = 1, `de` = 0, `line_start` = `frame_start` = 0, `frame_cnt` = 0.
- `frame_cnt` increments by 1 (mod 256) on each edge that asserts `frame_start`.

## Timing
- Latency is one `pix_ce` edge from internal state to outputs. All outputs are registered, with no combinational paths from inputs to outputs.
- After `rst` deasserts, the first `pix_ce` edge outputs pixel (0,0): `blank` = 0, `de` = 1, `line_start` = 1, `frame_start` = 1.
- The `frame_start` period is H_TOTAL×V_TOTAL `pix_ce` edges (420000 at defaults).
- With `pix_ce` tied to 1, the `pixel_clk` rate equals the pixel rate. With `pix_ce` toggling 1/0, the block can run from a 2× clock.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined: the 8-bit `frame_cnt` register exists and behaves as described in Operation.
- `VGA_TIMING_FRAME_CNT_EN` undefined: `frame_cnt` is constant 0 and no counter logic is synthesised. All other behaviour is identical.

## Test plan
- **Reset values:** hold `rst` = 1 for 5 cycles with `pix_ce` = 1. Outputs must read `HS` = 1, `VS` = 1, `blank` = 1, `de` = 0, counters = 0, strobes = 0. On the first edge after release: `hcounter` = 0, `vcounter` = 0, `blank` = 0, both strobes = 1.
- **Horizontal timing (defaults, `pix_ce` = 1):**
  - `HS` = 0 exactly while `hcounter` is in 656..751 (96 cycles).
  - `blank` = 1 for `hcounter` 640..799.
  - `hcounter` never reaches 800.
  - The `line_start` period is 800 cycles.
- **Vertical timing and period:**
  - `VS` = 0 exactly for lines 490..491 (1600 cycles).
  - The `frame_start` period is 420000 cycles.
  - `vcounter` wraps 524 → 0.
- **Clock enable (`pix_ce` alternating 1,0):**
  - The `frame_start` period is 840000 cycles.
  - Each strobe lasts exactly 1 `pixel_clk` cycle.
  - Other outputs hold through `pix_ce` = 0 cycles.
- **Mid-frame reset:** assert `rst` for 1 cycle at `hcounter` = 300, `vcounter` = 200. The next edges must show reset values, then pixel (0,0) with `frame_start` = 1.
- **Parameter and macro variants:**
  - `HS_POL` = 1, `VS_POL` = 1: sync levels invert; reset value of `HS` = 0.
  - With `VGA_TIMING_FRAME_CNT_EN`: `frame_cnt` reads 255 → 0 across frame 256.
  - Without the macro: `frame_cnt` stays 0.
